// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier accumulation stage.
package mult_pkg;

    localparam int PROD_W    = 19;
    localparam int ACC_W_DEF = 24;

    typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

    typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mult_valid_dly.sv
// Latency-matched strobe delay: a strobe in cycle t appears on tap in cycle t+MUL_LAT.
// pending reports whether any strobe is still travelling through the delay.
module mult_valid_dly
    import mult_pkg::*;
#(
    parameter int MUL_LAT = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic strobe,
    output logic tap,
    output logic pending
);

    logic [MUL_LAT-1:0] vld_p;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | MUL_LAT'(strobe);
        end
    end

    assign tap     = vld_p[MUL_LAT-1];
    assign pending = |vld_p;

endmodule

// File: rtl/mult_acc_ctrl.sv
// Frame accumulator behind the pipelined multiplier, with a 2-entry output buffer.
// Define MULT_ACC_SAT_EN for saturating accumulation; otherwise sums wrap modulo 2^ACC_W.
module mult_acc_ctrl #(
    parameter int MUL_LAT   = 7,
    parameter int PROD_W    = mult_pkg::PROD_W,
    parameter int ACC_W     = mult_pkg::ACC_W_DEF,
    parameter int FRAME_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     clr,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic                     busy
);
    import mult_pkg::*;

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    typedef logic signed [ACC_W-1:0] acc_t;

    acc_state_t       state;
    acc_t             acc;
    acc_t             prod_x;
    acc_t             sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             prod_vld;
    logic             pipe_busy;
    logic             last;
    logic             push;
    logic             push_ok;
    logic             pop;
    acc_t             fifo_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       fill;

`ifdef MULT_ACC_SAT_EN
    localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
    localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-1){1'b0}}});

    function automatic logic add_ovf(input acc_t a, input acc_t b);
        acc_t raw;
        raw = a + b;
        return (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    endfunction

    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        if (add_ovf(a, b)) return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return a + b;
    endfunction

    logic sat_hold;
`endif

    mult_valid_dly #(.MUL_LAT(MUL_LAT)) u_vld (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .strobe  (in_valid),
        .tap     (prod_vld),
        .pending (pipe_busy)
    );

    assign prod_x = ACC_W'(prod);
    // cnt is 0 in IDLE, so the same compare covers FRAME_LEN == 1 straight from IDLE
    assign last   = (cnt == CNT_W'(FRAME_LEN - 1));

    always_comb begin
`ifdef MULT_ACC_SAT_EN
        sum_nxt = sat_hold ? acc : sat_add(acc, prod_x);
`else
        sum_nxt = acc + prod_x;
`endif
    end

    assign push    = prod_vld && last && !clr;
    assign pop     = out_valid && out_ready;
    assign push_ok = push && ((fill != 2'd2) || pop);
    assign wr_ptr  = rd_ptr ^ fill[0];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= ACC_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (prod_vld) begin
            if (last) begin
                state <= ACC_IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                state <= ACC_RUN;
                acc   <= sum_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef MULT_ACC_SAT_EN
    // Once clamped, the frame keeps the clamp value until it completes
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sat_hold <= 1'b0;
        end else if (prod_vld) begin
            sat_hold <= last ? 1'b0 : (sat_hold || add_ovf(acc, prod_x));
        end
    end
`endif

    // When full with a coincident pop, wr_ptr equals rd_ptr: the head slot is recycled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill        <= '0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) fifo_mem[wr_ptr] <= sum_nxt;
            if (pop) rd_ptr <= ~rd_ptr;
            fill <= fill + 2'(push_ok) - 2'(pop);
            if (clr) begin
                overflow <= 1'b0;
            end else if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (fill != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign busy      = (state != ACC_IDLE) || pipe_busy;

endmodule

// File: tb/tb_mult_acc_ctrl.sv
// Self-checking bench for mult_acc_ctrl (FRAME_LEN=4, ACC_W=20) with a queue-based reference model.
module tb_mult_acc_ctrl;

    localparam int MUL_LAT   = 7;
    localparam int PROD_W    = 19;
    localparam int ACC_W     = 20;
    localparam int FRAME_LEN = 4;
    localparam longint AMAX  = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint AMIN  = -(longint'(1) << (ACC_W - 1));
    localparam longint AMOD  = longint'(1) << ACC_W;

`ifdef MULT_ACC_SAT_EN
    localparam longint SAT_E0 = 524287;
    localparam longint SAT_E1 = -524288;
    localparam longint SAT_E2 = 524287;
`else
    localparam longint SAT_E0 = -524288;
    localparam longint SAT_E1 = 0;
    localparam longint SAT_E2 = 524285;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [PROD_W-1:0] prod;
    logic                     clr;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ready;
    logic                     overflow;
    logic                     busy;

    always #5 clk = ~clk;

    mult_acc_ctrl #(
        .MUL_LAT(MUL_LAT), .PROD_W(PROD_W), .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .prod      (prod),
        .clr       (clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Reference model: issued strobes/products in flight, current frame, output queue
    bit     vq[$];
    int     pq[$];
    int     cur[$];
    longint mq[$];
    bit     mov;
    int     n_tests = 0;
    int     n_fail  = 0;

    function automatic longint frame_sum(input int f[$]);
        longint s = 0;
        bit sat = 0;
        foreach (f[i]) begin
            if (!sat) begin
                s += f[i];
`ifdef MULT_ACC_SAT_EN
                if (s > AMAX) begin s = AMAX; sat = 1; end
                else if (s < AMIN) begin s = AMIN; sat = 1; end
`endif
            end
        end
        s = s & (AMOD - 1);
        if (s > AMAX) s -= AMOD;
        return s;
    endfunction

    function automatic bit model_busy();
        bit b = (cur.size() != 0);
        foreach (vq[i]) b |= vq[i];
        return b;
    endfunction

    task automatic tick(input bit v, input int p, input bit c, input bit r);
        bit pv;
        int pp;
        longint s;
        pv = vq[0];
        pp = pq[0];
        in_valid  = v;
        clr       = c;
        out_ready = r;
        prod = pv ? PROD_W'(pp) : PROD_W'($urandom);
        @(posedge clk);
        void'(vq.pop_front());
        void'(pq.pop_front());
        vq.push_back(v);
        pq.push_back(p);
        if (r && mq.size() > 0) void'(mq.pop_front());
        if (c) begin
            cur.delete();
            foreach (vq[i]) vq[i] = 0;
            mov = 0;
        end else if (pv) begin
            cur.push_back(pp);
            if (cur.size() == FRAME_LEN) begin
                s = frame_sum(cur);
                cur.delete();
                if (mq.size() < 2) mq.push_back(s);
                else mov = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) tick(0, 0, 0, r);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        tick(1, a, 0, 0); tick(1, b, 0, 0); tick(1, c, 0, 0); tick(1, d, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; prod = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vq.delete(); pq.delete(); cur.delete(); mq.delete(); mov = 0;
        for (int i = 0; i < MUL_LAT; i++) begin vq.push_back(0); pq.push_back(0); end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        send4(3, -5, 100, -1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b want 1", busy); end
        idle(MUL_LAT - 1, 0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
        idle(1, 0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got %0b want 1", out_valid); end
        n_tests++; if (longint'(out_data) !== 97) begin n_fail++; $display("FAIL basic_sum got %0d want 97", out_data); end
        idle(2, 0);
        n_tests++; if (longint'(out_data) !== 97 || out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold got %0d/%0b want 97/1", out_data, out_valid); end
        idle(1, 1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %0b want 0", out_valid); end
    endtask

    task automatic test_gapped();
        tick(1, 10, 0, 0); idle(2, 0);
        tick(1, 20, 0, 0); idle(2, 0);
        tick(1, 30, 0, 0); idle(2, 0);
        tick(1, 40, 0, 0);
        send4(1, 1, 1, 1);
        idle(MUL_LAT + 1, 0);
        n_tests++; if (longint'(out_data) !== 100 || out_valid !== 1'b1) begin n_fail++; $display("FAIL gapped_sum got %0d/%0b want 100/1", out_data, out_valid); end
        idle(1, 1);
        n_tests++; if (longint'(out_data) !== 4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sum got %0d/%0b want 4/1", out_data, out_valid); end
        idle(1, 1);
        n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL gapped_drain got v%0b ov%0b want v0 ov0", out_valid, overflow); end
    endtask

    task automatic test_backpressure();
        send4(1, 1, 1, 2);
        send4(1, 2, 1, 2);
        send4(1, 2, 2, 2);
        idle(MUL_LAT + 1, 0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %0b want 1", overflow); end
        n_tests++; if (longint'(out_data) !== 5) begin n_fail++; $display("FAIL bp_first got %0d want 5", out_data); end
        idle(1, 1);
        n_tests++; if (longint'(out_data) !== 6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got %0d/%0b want 6/1", out_data, out_valid); end
        idle(1, 1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %0b want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        tick(0, 0, 1, 0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ppf_clr_ov got %0b want 0", overflow); end
        send4(2, 3, 3, 3);
        send4(3, 3, 3, 3);
        send4(4, 3, 3, 3);
        for (int j = 0; j < MUL_LAT + 1; j++) tick(0, 0, 0, j == MUL_LAT - 1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ppf_overflow got %0b want 0", overflow); end
        n_tests++; if (longint'(out_data) !== 12) begin n_fail++; $display("FAIL ppf_head got %0d want 12", out_data); end
        idle(1, 1);
        n_tests++; if (longint'(out_data) !== 13 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ppf_next got %0d/%0b want 13/1", out_data, out_valid); end
        idle(1, 1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ppf_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_clr();
        tick(1, 1, 0, 0); tick(1, 1, 0, 0);
        idle(MUL_LAT, 0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_run got %0b want 1", busy); end
        tick(1, 5, 0, 0); tick(1, 5, 0, 0); tick(1, 5, 0, 0);
        tick(0, 0, 1, 0);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %0b want 0", busy); end
        idle(MUL_LAT + 1, 0);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_discard got v%0b b%0b want v0 b0", out_valid, busy); end
        send4(1, 2, 3, 4);
        idle(MUL_LAT + 1, 0);
        n_tests++; if (longint'(out_data) !== 10 || out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_fresh got %0d/%0b want 10/1", out_data, out_valid); end
        idle(1, 1);
    endtask

    task automatic test_saturation();
        longint exp_v[3];
        exp_v[0] = SAT_E0; exp_v[1] = SAT_E1; exp_v[2] = SAT_E2;
        for (int f = 0; f < 3; f++) begin
            case (f)
                0: send4(131072, 131072, 131072, 131072);
                1: send4(-262144, -262144, -262144, -262144);
                default: send4(262143, 262143, 262143, -262144);
            endcase
            idle(MUL_LAT + 1, 0);
            n_tests++;
            if (out_valid !== 1'b1 || mq.size() == 0 || longint'(out_data) !== exp_v[f] || longint'(out_data) !== mq[0]) begin
                n_fail++; $display("FAIL sat_frame%0d got %0d/%0b want %0d/1", f, out_data, out_valid, exp_v[f]);
            end
            idle(1, 1);
        end
    endtask

    task automatic test_random();
        bit v, c, r;
        int p;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 79) == 0);
            r = ($urandom_range(0, 2) == 0);
            p = int'($urandom_range(0, (1 << PROD_W) - 1)) - (1 << (PROD_W - 1));
            tick(v, p, c, r);
            n_tests++;
            if (out_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", i, out_valid, mq.size() != 0);
            end else if (mq.size() != 0 && longint'(out_data) !== mq[0]) begin
                n_fail++; $display("FAIL rnd_data cyc%0d got %0d want %0d", i, out_data, mq[0]);
            end else if (overflow !== mov) begin
                n_fail++; $display("FAIL rnd_overflow cyc%0d got %0b want %0b", i, overflow, mov);
            end else if (busy !== model_busy()) begin
                n_fail++; $display("FAIL rnd_busy cyc%0d got %0b want %0b", i, busy, model_busy());
            end
        end
    endtask

    task automatic test_reset_midframe();
        tick(1, 7, 0, 0); tick(1, 7, 0, 0);
        idle(MUL_LAT, 0);
        do_reset();
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid got b%0b v%0b want b0 v0", busy, out_valid); end
        send4(2, 2, 2, 2);
        idle(MUL_LAT + 1, 0);
        n_tests++; if (longint'(out_data) !== 8 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fresh got %0d/%0b want 8/1", out_data, out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_push_pop_full();
        test_clr();
        test_saturation();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_acc_ctrl.md
# mult_acc_ctrl

Downstream accumulation stage for the pipelined 11×8 signed multiplier. It tracks which multiplier output cycles carry real products by delaying the operand-issue strobe through a latency-matched valid pipe. It sums FRAME_LEN consecutive products per frame in a wide two's-complement accumulator. Completed frame sums go into a 2-entry output buffer drained over a valid/ready handshake, because the multiplier pipeline itself cannot stall.

## Interface
- MUL_LAT, 7: multiplier latency in cycles, from operand issue to registered product
- PROD_W, 19: product width, signed two's complement
- ACC_W, 24: accumulator and output width; must be ≥ PROD_W
- FRAME_LEN, 8: products per frame; range 1..255

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  high in the same cycle operands are presented to the multiplier
- prod  in  PROD_W  multiplier result, signed
- clr  in  1  synchronous frame abort
- out_valid  out  1  buffer non-empty
- out_data  out  ACC_W  head-of-buffer frame sum, signed
- out_ready  in  1  consumer accepts head
- overflow  out  1  sticky; a frame sum was dropped because the buffer was full
- busy  out  1  FSM not in IDLE, or any valid bit in flight

## Operation
- Valid pipe: MUL_LAT-bit shift register fed by in_valid. The tap is prod_vld, which is aligned with prod.
- Sign-extend prod to ACC_W before adding.
- FSM states:
  - IDLE: acc = 0, cnt = 0. prod_vld → RUN. If FRAME_LEN = 1, go straight to pushing.
  - RUN: each prod_vld does acc += prod and cnt++. On the FRAME_LEN-th product, go to IDLE.
- Push on the frame's last product: push acc + prod (not the registered acc) into the buffer, then clear acc and cnt in the same edge. Back-to-back frames run with no bubble.
- Gaps in prod_vld inside a frame are allowed; the FSM stays in RUN.
- Buffer: 2-entry FIFO.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full; occupancy is unchanged.
  - Push while full without a pop: the new sum is dropped, overflow is set, and buffer contents are unchanged.
- clr:
  - Zeroes acc, cnt, the valid pipe and overflow; FSM → IDLE.
  - Products already in flight are discarded.
  - Buffer contents are kept.
  - clr has priority over a coincident prod_vld.
- Wrap: ACC_W-bit modular arithmetic unless saturation is compiled in.

## Timing
- Reset values: out_valid = 0, out_data = 0, overflow = 0, busy = 0. Acc, cnt, valid pipe and buffer are all empty. FSM = IDLE.
- rst_n low mid-frame aborts identically to clr and also empties the buffer.
- Product latency: in_valid at cycle t → prod sampled at the edge ending cycle t+MUL_LAT.
- Frame latency: last product sampled at edge E → out_valid high in the cycle after E. Total: last operand issue to out_valid = MUL_LAT+1 cycles.
- out_data is stable while out_valid && !out_ready.
- out_valid may not drop without a pop.
- overflow asserts the cycle after the dropping edge.

## Configuration
- MULT_ACC_SAT_EN defined:
  - Each accumulate and final sum saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Saturation is detected per add from the operand signs and the result sign.
  - Once saturated, acc stays clamped until the frame ends.
- Undefined: plain wrap-around, with no extra logic.

## Structure
- Package mult_pkg:
  - PROD_W and the default ACC_W as constants.
  - typedef enum for FSM states {ACC_IDLE, ACC_RUN}.
  - typedef signed prod_t.
- Sub-module mult_valid_dly: parameterised MUL_LAT valid shift register with synchronous clear. It is reusable wherever the multiplier needs a strobe.
- The FIFO stays inline (2 entries, pointer + count).

## Test plan
- Basic frame, FRAME_LEN=4: products 3, −5, 100, −1 on consecutive cycles → one output of 97, out_valid 1 cycle after the 4th product edge.
- Gapped frame, FRAME_LEN=4: products 10, 20, 30, 40 with 2-cycle gaps → 100. Then a back-to-back next frame of 1, 1, 1, 1 → 4, with no lost products.
- Backpressure, out_ready=0: three complete frames of sums 5, 6, 7 → buffer holds 5, 6; overflow=1; releasing ready delivers 5 then 6 only.
- Simultaneous push/pop when full: with out_ready=1 pulsed on the completion edge → no drop, overflow stays 0, order preserved.
- clr mid-frame: after 2 of 4 products, pulse clr with 3 products in flight → those are discarded. A fresh frame of 1, 2, 3, 4 gives 10; busy=0 in between.
- Saturation, ACC_W=20, FRAME_LEN=8: eight products of 131072 → 524287 with MULT_ACC_SAT_EN, 0 without.
